// File: rtl/alu_sequencer.sv
// alu_sequencer: hardwired control FSM stepping fetch (T0-T2) and register-register ALU ops (T3-T5).
// Build option CTRL_MULDIV_EN enables mul/div opcodes, which add a T6 for the HI half of the result.
`timescale 1ns/1ps
module alu_sequencer (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        Mem_ready,
  input  logic        Start,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic        Read,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic [9:0]  Alu_sel,
  output logic        Run,
  output logic        Illegal
);

  typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;

  state_t     state;
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_alu, is_muldiv, is_nop, is_halt;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

`ifdef CTRL_MULDIV_EN
  assign is_muldiv = (opcode == 5'b01000) || (opcode == 5'b01001);
`else
  assign is_muldiv = 1'b0;
`endif
  assign is_alu  = (opcode[4:3] == 2'b00) || is_muldiv;
  assign is_nop  = (opcode == 5'b11000);
  assign is_halt = (opcode == 5'b11111);

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state <= RST;
    end else begin
      case (state)
        RST:  state <= T0;
        T0:   state <= T1;
        T1:   state <= Mem_ready ? T2 : T1;
        T2:   state <= T3;
        T3: begin
          if (is_alu)       state <= T4;
          else if (is_halt) state <= HALT;
          else              state <= T0;
        end
        T4:   state <= T5;
        T5:   state <= is_muldiv ? T6 : T0;
        T6:   state <= T0;
        HALT: state <= Start ? T0 : HALT;
        default: state <= RST;
      endcase
    end
  end

  // Moore decode of the state register; register fields only matter from T3 on
  always_comb begin
    PCout    = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Rout     = '0;
    Rin      = '0;
    Alu_sel  = '0;
    Illegal  = 1'b0;
    Run      = (state != RST) && (state != HALT);
    case (state)
      T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        if (is_alu) begin
          Rout[rb] = 1'b1;
          Yin      = 1'b1;
        end else if (!is_nop && !is_halt) begin
          Illegal = 1'b1;
        end
      end
      T4: begin
        Rout[rc] = 1'b1;
        Zin      = 1'b1;
        if (is_alu) Alu_sel[opcode[3:0]] = 1'b1;
      end
      T5: begin
        Zlowout = 1'b1;
`ifdef CTRL_MULDIV_EN
        if (is_muldiv) LOin = 1'b1;
        else           Rin[ra] = 1'b1;
`else
        Rin[ra] = 1'b1;
`endif
      end
      T6: begin
`ifdef CTRL_MULDIV_EN
        Zhighout = 1'b1;
        HIin     = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed vector table, hand-written reset/halt
// sequences, and random instruction streams checked against a per-instruction cycle model.
`timescale 1ns/1ps
module tb_alu_sequencer;

  logic        Clock, Clear, Mem_ready, Start;
  logic [31:0] IR;
  logic        PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin;
  logic        Yin, Zin, HIin, LOin, IncPC, Read, Run, Illegal;
  logic [15:0] Rout, Rin;
  logic [9:0]  Alu_sel;

  typedef struct packed {
    logic PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin;
    logic Yin, Zin, HIin, LOin, IncPC, Read;
    logic [15:0] Rout;
    logic [15:0] Rin;
    logic [9:0]  Alu_sel;
    logic Run, Illegal;
  } out_t;

  typedef struct {
    logic [31:0] ir;
    int          waits;
    int          hc;
    int          len;
    int          ill;
    int          rd;
  } vec_t;

`ifdef CTRL_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  out_t exp_q[$];

  alu_sequencer dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .Mem_ready(Mem_ready), .Start(Start),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read), .Rout(Rout), .Rin(Rin),
    .Alu_sel(Alu_sel), .Run(Run), .Illegal(Illegal)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic out_t sample();
    out_t o;
    o.PCout = PCout;   o.Zhighout = Zhighout; o.Zlowout = Zlowout; o.MDRout = MDRout;
    o.MARin = MARin;   o.PCin = PCin;         o.MDRin = MDRin;     o.IRin = IRin;
    o.Yin = Yin;       o.Zin = Zin;           o.HIin = HIin;       o.LOin = LOin;
    o.IncPC = IncPC;   o.Read = Read;         o.Rout = Rout;       o.Rin = Rin;
    o.Alu_sel = Alu_sel; o.Run = Run;         o.Illegal = Illegal;
    return o;
  endfunction

  function automatic out_t running();
    out_t o = '0;
    o.Run = 1'b1;
    return o;
  endfunction

  function automatic out_t t0_vec();
    out_t o = running();
    o.PCout = 1'b1; o.MARin = 1'b1; o.IncPC = 1'b1; o.Zin = 1'b1;
    return o;
  endfunction

  task automatic chk_o(input string name, input out_t got, input out_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_i(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Expected output vector for every cycle of one instruction, starting at its T0.
  task automatic build(input logic [31:0] ir, input int waits, input int hc);
    logic [4:0] op;
    bit         md, alu;
    out_t       o;
    op  = ir[31:27];
    md  = MULDIV && (op == 5'd8 || op == 5'd9);
    alu = (op < 5'd8) || md;
    exp_q = {};
    exp_q.push_back(t0_vec());
    for (int k = 0; k <= waits; k++) begin
      o = running();
      o.Zlowout = 1'b1; o.PCin = 1'b1; o.Read = 1'b1; o.MDRin = 1'b1;
      exp_q.push_back(o);
    end
    o = running();
    o.MDRout = 1'b1; o.IRin = 1'b1;
    exp_q.push_back(o);
    o = running();
    if (alu) begin
      o.Rout = 16'(1) << ir[22:19];
      o.Yin  = 1'b1;
    end else if (op != 5'd24 && op != 5'd31) begin
      o.Illegal = 1'b1;
    end
    exp_q.push_back(o);
    if (op == 5'd31)
      for (int k = 0; k < hc; k++) exp_q.push_back('0);
    if (alu) begin
      o = running();
      o.Rout = 16'(1) << ir[18:15]; o.Zin = 1'b1; o.Alu_sel = 10'(1) << op;
      exp_q.push_back(o);
      o = running();
      o.Zlowout = 1'b1;
      if (md) o.LOin = 1'b1;
      else    o.Rin  = 16'(1) << ir[26:23];
      exp_q.push_back(o);
      if (md) begin
        o = running();
        o.Zhighout = 1'b1; o.HIin = 1'b1;
        exp_q.push_back(o);
      end
    end
  endtask

  // Called at a falling edge while the DUT sits in T0; returns at the next T0.
  task automatic run_instr(input logic [31:0] ir, input int waits, input int hc,
                           output int len, output int ill, output int rd, output int irin);
    int   t1 = 0;
    int   hcnt = 0;
    bit   done = 0;
    out_t g;
    build(ir, waits, hc);
    IR = ir;
    len = 0; ill = 0; rd = 0; irin = 0;
    for (int i = 0; i < 200; i++) begin
      g = sample();
      if (i > 0 && g.PCout) begin
        done = 1;
        break;
      end
      len++;
      if (i < exp_q.size()) chk_o($sformatf("cycle%0d_ir%h", i, ir), g, exp_q[i]);
      else                  chk_i("overrun", i, exp_q.size());
      ill  += int'(g.Illegal);
      rd   += int'(g.Read);
      irin += int'(g.IRin);
      if (g.Read) begin
        Mem_ready = (t1 == waits);
        t1++;
      end else begin
        Mem_ready = 1'($urandom);
      end
      if (!g.Run) begin
        Start = (hcnt == hc - 1);
        hcnt++;
      end else begin
        Start = 1'b0;
      end
      @(negedge Clock);
    end
    Start = 1'b0;
    if (!done) chk_i("timeout_waiting_T0", len, exp_q.size());
    else       chk_i($sformatf("length_ir%h", ir), len, exp_q.size());
  endtask

  initial begin
    vec_t        vt[9];
    int          len, ill, rd, irin;
    logic [31:0] rir;
    int          r;

    vt[0] = '{32'h1A920000, 0, 0, 6, 0, 1};
    vt[1] = '{32'h1A920000, 3, 0, 9, 0, 4};
    vt[2] = '{32'hAFFF8000, 0, 0, 4, 1, 1};
    vt[3] = '{32'hC5550000, 0, 0, 4, 0, 1};
    vt[4] = '{32'hF8000000, 0, 20, 24, 0, 1};
    vt[5] = '{32'h41890000, 0, 0, MULDIV ? 7 : 4, MULDIV ? 0 : 1, 1};
    vt[6] = '{32'h07878000, 0, 0, 6, 0, 1};
    vt[7] = '{32'h48000000, 2, 0, MULDIV ? 9 : 6, MULDIV ? 0 : 1, 3};
    vt[8] = '{32'h30A50000, 1, 0, 7, 0, 2};

    Clear = 1'b1; IR = '0; Mem_ready = 1'b0; Start = 1'b0;
    #1 Clear = 1'b0;
    repeat (2) @(negedge Clock);
    chk_o("reset_outputs", sample(), '0);
    Clear = 1'b1;
    @(negedge Clock);
    chk_o("first_T0", sample(), t0_vec());

    for (int k = 0; k < 9; k++) begin
      run_instr(vt[k].ir, vt[k].waits, vt[k].hc, len, ill, rd, irin);
      chk_i($sformatf("vec%0d_len", k), len, vt[k].len);
      chk_i($sformatf("vec%0d_illegal", k), ill, vt[k].ill);
      chk_i($sformatf("vec%0d_read_cycles", k), rd, vt[k].rd);
      chk_i($sformatf("vec%0d_irin_cycles", k), irin, 1);
    end

    // Clear asserted mid-T4 takes effect without waiting for a clock edge
    IR = 32'h1A920000; Mem_ready = 1'b1;
    repeat (4) @(negedge Clock);
    chk_i("mid_T4_alu_sel", int'(Alu_sel), 32'h008);
    #2 Clear = 1'b0;
    #1 chk_o("clear_async", sample(), '0);
    @(negedge Clock);
    chk_o("clear_held", sample(), '0);
    Clear = 1'b1;
    @(negedge Clock);
    chk_o("clear_release_T0", sample(), t0_vec());

    // Clear beats Start while halted
    IR = 32'hF8000000; Mem_ready = 1'b1;
    repeat (4) @(negedge Clock);
    chk_o("halted", sample(), '0);
    Start = 1'b1; Clear = 1'b0;
    #1 chk_o("clear_vs_start_async", sample(), '0);
    @(negedge Clock);
    chk_o("clear_vs_start_edge", sample(), '0);
    Clear = 1'b1; Start = 1'b0;
    @(negedge Clock);
    chk_o("clear_vs_start_T0", sample(), t0_vec());

    for (int n = 0; n < 150; n++) begin
      r   = $urandom_range(0, 15);
      rir = $urandom;
      if (r <= 9)       rir[31:27] = 5'($urandom_range(0, 7));
      else if (r == 10) rir[31:27] = 5'($urandom_range(8, 9));
      else if (r == 11) rir[31:27] = 5'd24;
      else if (r == 12) rir[31:27] = 5'd31;
      run_instr(rir, $urandom_range(0, 3), $urandom_range(1, 5), len, ill, rd, irin);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
